// File: rtl/hs_pkg.sv
// Shared constants for the handshake source feeder and its synchronizer:
// default widths, FSM state encoding and a width helper.
package hs_pkg;

    localparam int HS_WIDTH     = 8;
    localparam int HS_DEPTH     = 16;
    localparam int HS_FRAME_LEN = 32;

    // Launch FSM encoding (2-bit, plain constants for legacy tools)
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LAUNCH   = 2'd1;
    localparam logic [1:0] ST_GUARD    = 2'd2;
    localparam logic [1:0] ST_WAIT_ACK = 2'd3;

    // Ceiling log2; returns 0 for values of 1 or less
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/hs_src_feeder_if.sv
// Bundle of the input word stream, the synchronizer source port and the
// feeder status outputs. slave is the feeder side, master the driver side.
interface hs_src_feeder_if #(
    parameter int WIDTH = hs_pkg::HS_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             sidle;
    logic             sready;
    logic [WIDTH-1:0] din;
    logic             frame_done;
    logic             ovf_err;
    logic             busy;

    modport slave (
        input  in_valid, in_data, sidle,
        output in_ready, sready, din, frame_done, ovf_err, busy
    );

    modport master (
        output in_valid, in_data, sidle,
        input  in_ready, sready, din, frame_done, ovf_err, busy
    );
endinterface

// File: rtl/hs_sync_fifo.sv
// Single-clock FIFO. Read data is registered and only changes on a pop,
// so the output doubles as the word presented to the synchronizer.
module hs_sync_fifo
    import hs_pkg::*;
#(
    parameter int WIDTH = HS_WIDTH,
    parameter int DEPTH = HS_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [clog2(DEPTH):0]    count_o
);
    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] rdata_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = rdata_q;

    // Requests are qualified here so a push on full or pop on empty is ignored
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Occupancy update; simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers, count and registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                rdata_q  <= mem_q[rd_ptr_q];
            end
        end
    end

endmodule

// File: rtl/hs_src_feeder.sv
// Source-domain feeder for the two-phase handshake synchronizer: buffers
// bursty input words and launches them one at a time, never issuing a new
// sready until the previous request/acknowledge round trip has completed.
module hs_src_feeder
    import hs_pkg::*;
#(
    parameter int WIDTH     = HS_WIDTH,
    parameter int DEPTH     = HS_DEPTH,
    parameter int FRAME_LEN = HS_FRAME_LEN
) (
    input logic            clk,
    input logic            rst,
    hs_src_feeder_if.slave bus
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = (FRAME_LEN > 1) ? clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    logic             fifo_full, fifo_empty;
    logic [AW:0]      fifo_count;
    logic [WIDTH-1:0] fifo_rdata;
    logic             push, pop;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    word_cnt_q, word_cnt_d;
    logic             sready_q, frame_done_q, ovf_err_q;
    logic             last_word;

    // in_ready uses the pre-pop occupancy: a full FIFO refuses a write even
    // when a pop happens on the same edge
    assign push = bus.in_valid && !fifo_full;

    // Only pop when the synchronizer is idle, so the popped word is launched
    // on the very next cycle
    assign pop = (state_q == ST_IDLE) && !fifo_empty && bus.sidle;

    assign last_word = (word_cnt_q == LAST_CNT);

    hs_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (bus.in_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Launch sequencing: LAUNCH and GUARD each last one cycle, then wait for
    // the synchronizer to report idle again
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (pop) state_d = ST_LAUNCH;
            ST_LAUNCH:   state_d = ST_GUARD;
            ST_GUARD:    state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: if (bus.sidle) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Frame word counter advances as each LAUNCH cycle completes
    always_comb begin
        word_cnt_d = word_cnt_q;
        if (state_q == ST_LAUNCH) begin
            word_cnt_d = last_word ? '0 : word_cnt_q + 1'b1;
        end
    end

    // Control registers; sready/frame_done are set on the pop edge so they
    // are high exactly during LAUNCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            sready_q     <= 1'b0;
            frame_done_q <= 1'b0;
            ovf_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            sready_q     <= pop;
            frame_done_q <= pop && last_word;
            if (bus.in_valid && fifo_full) begin
                ovf_err_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = !fifo_full;
    assign bus.sready     = sready_q;
    assign bus.din        = fifo_rdata;
    assign bus.frame_done = frame_done_q;
    assign bus.ovf_err    = ovf_err_q;
    assign bus.busy       = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_hs_src_feeder.sv
// Bench for hs_src_feeder: a small synchronizer model supplies sidle with a
// programmable round trip, launches are recorded and matched against a
// queue of expected words.
module tb_hs_src_feeder;
    import hs_pkg::*;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int FL = 32;

    typedef struct {
        logic [W-1:0] d;
        logic         fd;
        int unsigned  cyc;
    } launch_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hs_src_feeder_if #(.WIDTH(W)) bus();

    hs_src_feeder #(.WIDTH(W), .DEPTH(D), .FRAME_LEN(FL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    launch_t      got_q[$];
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int unsigned  cyc      = 0;
    int           rt_len   = 0;
    int           rt_cnt   = 0;
    bit           stall    = 1'b0;
    bit           consec_seen = 1'b0;
    bit           orphan_fd   = 1'b0;
    logic         prev_sready = 1'b0;

    // Synchronizer source-side model: a launch makes sidle low for rt_len cycles
    assign bus.sidle = (rt_cnt == 0) && !stall;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) rt_cnt <= 0;
        else if (bus.sready && bus.sidle) rt_cnt <= rt_len;
        else if (rt_cnt != 0) rt_cnt <= rt_cnt - 1;
    end

    // Launch recorder, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.sready) got_q.push_back('{d: bus.din, fd: bus.frame_done, cyc: cyc});
        if (bus.sready && prev_sready) consec_seen <= 1'b1;
        if (bus.frame_done && !bus.sready) orphan_fd <= 1'b1;
        prev_sready <= bus.sready;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // Drives one word for one cycle; called and returns on a falling edge
    task automatic write_word(input logic [W-1:0] d, input bit accept);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        if (accept) exp_q.push_back(d);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic write_blocking(input logic [W-1:0] d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) write_word(d, 1'b1);
    endtask

    task automatic wait_launches(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (got_q.size() >= n) break;
            @(posedge clk);
        end
        ok = (got_q.size() >= n);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        consec_seen = 1'b0;
        orphan_fd   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.sready !== 1'b0) $display("FAIL reset_sready: got %b want 0", bus.sready); else n_pass++;
        n_checks++; if (bus.din !== 8'h00) $display("FAIL reset_din: got %h want 00", bus.din); else n_pass++;
        n_checks++; if (bus.frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", bus.frame_done); else n_pass++;
        n_checks++; if (bus.ovf_err !== 1'b0) $display("FAIL reset_ovf_err: got %b want 0", bus.ovf_err); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_single();
        launch_t     l;
        logic [W-1:0] e;
        int unsigned wr_cyc;
        bit          ok;
        rt_len = 0;
        write_word(8'hA5, 1'b1);
        wr_cyc = cyc;
        wait_launches(1, 20, ok);
        n_checks++; if (!ok) $display("FAIL single_timeout: got %0d launches want 1", got_q.size()); else n_pass++;
        if (ok) begin
            l = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++; if (l.d !== e) $display("FAIL single_din: got %h want %h", l.d, e); else n_pass++;
            // sready is high in the cycle after the pop edge, which follows the
            // write edge, so the synchronizer captures on the second edge
            n_checks++; if (l.cyc - wr_cyc != 1) $display("FAIL single_latency: got %0d want 1", l.cyc - wr_cyc); else n_pass++;
        end
        repeat (8) @(negedge clk);
        n_checks++; if (got_q.size() != 0) $display("FAIL single_extra: got %0d extra launches want 0", got_q.size()); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL single_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.din !== 8'hA5) $display("FAIL single_din_hold: got %h want a5", bus.din); else n_pass++;
    endtask

    task automatic test_burst();
        logic [W-1:0] words[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        launch_t      l;
        logic [W-1:0] e;
        int unsigned  prev_cyc;
        bit           ok;
        rt_len = 6;
        prev_cyc = 0;
        consec_seen = 1'b0;
        foreach (words[i]) write_word(words[i], 1'b1);
        wait_launches(4, 200, ok);
        n_checks++; if (!ok) $display("FAIL burst_timeout: got %0d launches want 4", got_q.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (got_q.size() == 0) break;
            l = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++; if (l.d !== e) $display("FAIL burst_din%0d: got %h want %h", i, l.d, e); else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (l.cyc - prev_cyc < 9) $display("FAIL burst_spacing%0d: got %0d want >=9", i, l.cyc - prev_cyc);
                else n_pass++;
            end
            prev_cyc = l.cyc;
        end
        n_checks++; if (consec_seen !== 1'b0) $display("FAIL burst_consec: got %b want 0", consec_seen); else n_pass++;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_overflow();
        launch_t      l;
        logic [W-1:0] e;
        bit           ok;
        rt_len = 2;
        stall  = 1'b1;
        for (int i = 0; i < 16; i++) write_word(W'(8'h40 + i), 1'b1);
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL ovf_in_ready: got %b want 0", bus.in_ready); else n_pass++;
        n_checks++; if (bus.ovf_err !== 1'b0) $display("FAIL ovf_early: got %b want 0", bus.ovf_err); else n_pass++;
        write_word(8'hEE, 1'b0);
        n_checks++; if (bus.ovf_err !== 1'b1) $display("FAIL ovf_set: got %b want 1", bus.ovf_err); else n_pass++;
        stall = 1'b0;
        wait_launches(16, 400, ok);
        n_checks++; if (!ok) $display("FAIL ovf_timeout: got %0d launches want 16", got_q.size()); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            if (got_q.size() == 0) break;
            l = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++; if (l.d !== e) $display("FAIL ovf_din%0d: got %h want %h", i, l.d, e); else n_pass++;
        end
        repeat (10) @(negedge clk);
        n_checks++; if (got_q.size() != 0) $display("FAIL ovf_extra: got %0d extra launches want 0", got_q.size()); else n_pass++;
        n_checks++; if (bus.ovf_err !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", bus.ovf_err); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL ovf_busy: got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_frame();
        launch_t      l;
        logic [W-1:0] e;
        bit           ok, all_ok;
        int           fd_cnt;
        do_reset();
        rt_len = 0;
        all_ok = 1'b1;
        for (int i = 0; i < 64; i++) begin
            write_blocking(W'(i + 1), ok);
            all_ok = all_ok && ok;
        end
        n_checks++; if (!all_ok) $display("FAIL frame_write_timeout: got stalled want all 64 written"); else n_pass++;
        wait_launches(64, 600, ok);
        n_checks++; if (!ok) $display("FAIL frame_timeout: got %0d launches want 64", got_q.size()); else n_pass++;
        fd_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (got_q.size() == 0) break;
            l = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++; if (l.d !== e) $display("FAIL frame_din%0d: got %h want %h", i, l.d, e); else n_pass++;
            n_checks++;
            if (l.fd !== ((i == 31) || (i == 63))) $display("FAIL frame_done%0d: got %b want %b", i, l.fd, (i == 31) || (i == 63));
            else n_pass++;
            if (l.fd) fd_cnt++;
        end
        n_checks++; if (fd_cnt != 2) $display("FAIL frame_count: got %0d want 2", fd_cnt); else n_pass++;
        n_checks++; if (orphan_fd !== 1'b0) $display("FAIL frame_orphan: got %b want 0", orphan_fd); else n_pass++;
        n_checks++; if (consec_seen !== 1'b0) $display("FAIL frame_consec: got %b want 0", consec_seen); else n_pass++;
        repeat (6) @(negedge clk);
        n_checks++; if (dut.word_cnt_q !== '0) $display("FAIL frame_word_cnt: got %0d want 0", dut.word_cnt_q); else n_pass++;
    endtask

    task automatic test_push_pop();
        launch_t      l;
        logic [W-1:0] e;
        bit           ok;
        rt_len = 3;
        stall  = 1'b1;
        write_word(8'h71, 1'b1);
        stall = 1'b0;
        write_word(8'h72, 1'b1);
        n_checks++; if (dut.u_fifo.count_q !== 5'd1) $display("FAIL pp_count1: got %0d want 1", dut.u_fifo.count_q); else n_pass++;
        wait_launches(2, 100, ok);
        n_checks++; if (!ok) $display("FAIL pp_timeout: got %0d launches want 2", got_q.size()); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            if (got_q.size() == 0) break;
            l = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++; if (l.d !== e) $display("FAIL pp_din%0d: got %h want %h", i, l.d, e); else n_pass++;
        end
        repeat (10) @(negedge clk);
        n_checks++; if (got_q.size() != 0) $display("FAIL pp_extra: got %0d extra launches want 0", got_q.size()); else n_pass++;

        // Full FIFO with a pop on the same edge as a write: write refused
        stall = 1'b1;
        for (int i = 0; i < 16; i++) write_word(W'(8'h80 + i), 1'b1);
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL ppf_in_ready: got %b want 0", bus.in_ready); else n_pass++;
        stall = 1'b0;
        write_word(8'hFF, 1'b0);
        n_checks++; if (dut.u_fifo.count_q !== 5'd15) $display("FAIL ppf_count: got %0d want 15", dut.u_fifo.count_q); else n_pass++;
        n_checks++; if (bus.ovf_err !== 1'b1) $display("FAIL ppf_ovf: got %b want 1", bus.ovf_err); else n_pass++;
        wait_launches(16, 400, ok);
        n_checks++; if (!ok) $display("FAIL ppf_timeout: got %0d launches want 16", got_q.size()); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            if (got_q.size() == 0) break;
            l = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++; if (l.d !== e) $display("FAIL ppf_din%0d: got %h want %h", i, l.d, e); else n_pass++;
        end
        repeat (10) @(negedge clk);
        n_checks++; if (got_q.size() != 0) $display("FAIL ppf_extra: got %0d extra launches want 0", got_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        launch_t      l;
        logic [W-1:0] e;
        rt_len = 10;
        for (int i = 0; i < 6; i++) write_word(W'(8'h90 + i), 1'b1);
        n_checks++; if (got_q.size() != 1) $display("FAIL rm_first_launch: got %0d launches want 1", got_q.size()); else n_pass++;
        n_checks++; if (dut.state_q !== ST_WAIT_ACK) $display("FAIL rm_pre_state: got %0d want %0d", dut.state_q, ST_WAIT_ACK); else n_pass++;
        n_checks++; if (dut.u_fifo.count_q !== 5'd5) $display("FAIL rm_pre_count: got %0d want 5", dut.u_fifo.count_q); else n_pass++;
        if (got_q.size() > 0) begin
            l = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++; if (l.d !== e) $display("FAIL rm_din: got %h want %h", l.d, e); else n_pass++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        n_checks++; if (dut.state_q !== ST_IDLE) $display("FAIL rm_state: got %0d want %0d", dut.state_q, ST_IDLE); else n_pass++;
        n_checks++; if (dut.u_fifo.count_q !== 5'd0) $display("FAIL rm_count: got %0d want 0", dut.u_fifo.count_q); else n_pass++;
        n_checks++; if (bus.sready !== 1'b0) $display("FAIL rm_sready: got %b want 0", bus.sready); else n_pass++;
        n_checks++; if (bus.ovf_err !== 1'b0) $display("FAIL rm_ovf: got %b want 0", bus.ovf_err); else n_pass++;
        n_checks++; if (dut.word_cnt_q !== '0) $display("FAIL rm_word_cnt: got %0d want 0", dut.word_cnt_q); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", bus.busy); else n_pass++;
        repeat (40) @(negedge clk);
        n_checks++; if (got_q.size() != 0) $display("FAIL rm_stale: got %0d launches want 0", got_q.size()); else n_pass++;
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_frame();
        test_push_pop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
